// File: rtl/pad_analog_pkg.sv
// Shared types and helpers for the analog pad switch controller family.
package pad_analog_pkg;

  // Widest switch bank any controller in this family can drive.
  localparam int unsigned MaxNch = 32;

  typedef enum logic [2:0] {
    StIsolated,
    StOpen,
    StBreak,
    StSettle,
    StConnected
  } pad_analog_state_t;

  // Channel index to one-hot switch vector; callers truncate to their bank width.
  function automatic logic [MaxNch-1:0] onehot(input int unsigned idx);
    logic [MaxNch-1:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

  // Down-counter width able to hold the larger of two cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pad_analog_timer.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module pad_analog_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over counting; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_analog_sw_ctrl.sv
// Break-before-make sequencer for a bank of analog pad switches sharing one
// internal node. At most one switch is ever closed; every close is preceded by
// a dead time with all switches open, and SETTLED follows a settle interval.
module pad_analog_sw_ctrl
  import pad_analog_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned DEAD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  localparam int unsigned CHW          = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           SEL_VALID,
  output logic           SEL_READY,
  input  logic           SEL_EN,
  input  logic [CHW-1:0] SEL_CH,
  input  logic           ISOL_REQ,
  output logic [NCH-1:0] SW_EN,
  output logic [CHW-1:0] CUR_CH,
  output logic           ISOL,
  output logic           BUSY,
  output logic           SETTLED,
  output logic           ERR
);

  localparam int unsigned CntW = cnt_width(DEAD_CYCLES, SETTLE_CYCLES);
  // Loaded with N-1 so the transition fires exactly N edges after entry.
  localparam logic [CntW-1:0] DeadLoad   = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  pad_analog_state_t state_q, state_d;
  logic [CHW-1:0]    cur_ch_q, cur_ch_d;
  logic              pend_conn_q, pend_conn_d;
  logic [NCH-1:0]    sw_en_q, sw_en_d;
  logic              isol_q, isol_d;
  logic              busy_q, busy_d;
  logic              settled_q, settled_d;
  logic              err_q, err_d;
  logic              sel_ready_q, sel_ready_d;

  logic              tmr_load;
  logic [CntW-1:0]   tmr_load_val;
  logic              tmr_zero;
  logic              accept;
  logic              ch_illegal;

  pad_analog_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  assign accept     = SEL_VALID && sel_ready_q;
  assign ch_illegal = (32'(SEL_CH) >= NCH);

  // Next state, then registered outputs decoded from the next state.
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    pend_conn_d  = pend_conn_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    err_d        = 1'b0;

    unique case (state_q)
      StIsolated: state_d = StOpen;
      StOpen, StConnected: begin
        if (accept) begin
          if (!SEL_EN) begin
            state_d      = StBreak;
            pend_conn_d  = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = DeadLoad;
          end else if (ch_illegal) begin
            err_d = 1'b1;
          end else if (!(state_q == StConnected && SEL_CH == cur_ch_q)) begin
            // Even from OPEN the close goes through BREAK to guarantee dead time.
            state_d      = StBreak;
            cur_ch_d     = SEL_CH;
            pend_conn_d  = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = DeadLoad;
          end
        end
      end
      StBreak: begin
        if (tmr_zero) begin
          if (pend_conn_q) begin
            state_d      = StSettle;
            tmr_load     = 1'b1;
            tmr_load_val = SettleLoad;
          end else begin
            state_d = StOpen;
          end
        end
      end
      StSettle: begin
        if (tmr_zero) begin
          state_d = StConnected;
        end
      end
      default: state_d = StIsolated;
    endcase

    // Isolation overrides everything, including a request taken this edge.
    if (ISOL_REQ) begin
      state_d     = StIsolated;
      cur_ch_d    = cur_ch_q;
      pend_conn_d = pend_conn_q;
      tmr_load    = 1'b0;
      err_d       = 1'b0;
    end

    sw_en_d = '0;
    if (state_d == StSettle || state_d == StConnected) begin
      sw_en_d = NCH'(onehot(32'(cur_ch_d)));
    end
    isol_d      = (state_d == StIsolated);
    busy_d      = (state_d == StBreak) || (state_d == StSettle);
    settled_d   = (state_d == StConnected);
    sel_ready_d = (state_d == StOpen) || (state_d == StConnected);
  end

  // State and output registers; reset opens every switch without a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIsolated;
      cur_ch_q    <= '0;
      pend_conn_q <= 1'b0;
      sw_en_q     <= '0;
      isol_q      <= 1'b1;
      busy_q      <= 1'b0;
      settled_q   <= 1'b0;
      err_q       <= 1'b0;
      sel_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      pend_conn_q <= pend_conn_d;
      sw_en_q     <= sw_en_d;
      isol_q      <= isol_d;
      busy_q      <= busy_d;
      settled_q   <= settled_d;
      err_q       <= err_d;
      sel_ready_q <= sel_ready_d;
    end
  end

  assign SW_EN     = sw_en_q;
  assign CUR_CH    = cur_ch_q;
  assign ISOL      = isol_q;
  assign BUSY      = busy_q;
  assign SETTLED   = settled_q;
  assign ERR       = err_q;
  assign SEL_READY = sel_ready_q;

endmodule

// File: tb/tb_pad_analog_sw_ctrl.sv
// Directed bench: default bank, a 6-channel bank, a 3-channel bank and a
// minimal-timing bank share clock and reset.
module tb_pad_analog_sw_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default instance (NCH=4, DEAD=4, SETTLE=8)
  logic       m_valid, m_en, m_isol;
  logic [1:0] m_ch;
  logic       m_ready, m_isol_o, m_busy, m_settled, m_err;
  logic [3:0] m_sw;
  logic [1:0] m_cur;

  // NCH=6
  logic       s_valid, s_en, s_isol;
  logic [2:0] s_ch;
  logic       s_ready, s_isol_o, s_busy, s_settled, s_err;
  logic [5:0] s_sw;
  logic [2:0] s_cur;

  // NCH=3
  logic       t_valid, t_en, t_isol;
  logic [1:0] t_ch;
  logic       t_ready, t_isol_o, t_busy, t_settled, t_err;
  logic [2:0] t_sw;
  logic [1:0] t_cur;

  // DEAD=1, SETTLE=1
  logic       n_valid, n_en, n_isol;
  logic [1:0] n_ch;
  logic       n_ready, n_isol_o, n_busy, n_settled, n_err;
  logic [3:0] n_sw;
  logic [1:0] n_cur;

  pad_analog_sw_ctrl dut (
    .CLK (clk), .RESET (rst), .SEL_VALID (m_valid), .SEL_READY (m_ready), .SEL_EN (m_en),
    .SEL_CH (m_ch), .ISOL_REQ (m_isol), .SW_EN (m_sw), .CUR_CH (m_cur), .ISOL (m_isol_o),
    .BUSY (m_busy), .SETTLED (m_settled), .ERR (m_err)
  );

  pad_analog_sw_ctrl #(.NCH (6)) dut6 (
    .CLK (clk), .RESET (rst), .SEL_VALID (s_valid), .SEL_READY (s_ready), .SEL_EN (s_en),
    .SEL_CH (s_ch), .ISOL_REQ (s_isol), .SW_EN (s_sw), .CUR_CH (s_cur), .ISOL (s_isol_o),
    .BUSY (s_busy), .SETTLED (s_settled), .ERR (s_err)
  );

  pad_analog_sw_ctrl #(.NCH (3)) dut3 (
    .CLK (clk), .RESET (rst), .SEL_VALID (t_valid), .SEL_READY (t_ready), .SEL_EN (t_en),
    .SEL_CH (t_ch), .ISOL_REQ (t_isol), .SW_EN (t_sw), .CUR_CH (t_cur), .ISOL (t_isol_o),
    .BUSY (t_busy), .SETTLED (t_settled), .ERR (t_err)
  );

  pad_analog_sw_ctrl #(.DEAD_CYCLES (1), .SETTLE_CYCLES (1)) dut_min (
    .CLK (clk), .RESET (rst), .SEL_VALID (n_valid), .SEL_READY (n_ready), .SEL_EN (n_en),
    .SEL_CH (n_ch), .ISOL_REQ (n_isol), .SW_EN (n_sw), .CUR_CH (n_cur), .ISOL (n_isol_o),
    .BUSY (n_busy), .SETTLED (n_settled), .ERR (n_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full connect on the default instance from OPEN/CONNECTED; k=0 is the accept edge.
  task automatic main_conn(input logic [1:0] ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    m_valid = 1'b1;
    m_en    = 1'b1;
    m_ch    = ch;
    for (int k = 0; k <= 12; k++) begin
      tick();
      if (k == 0) begin
        m_valid = 1'b0;
        check("conn_cur_ch", 32'(m_cur), 32'(ch));
        check("conn_busy", 32'(m_busy), 32'd1);
        check("conn_ready_low", 32'(m_ready), 32'd0);
      end
      check($sformatf("conn%0d_sw_k%0d", ch, k), 32'(m_sw), (k >= 4) ? 32'(oh) : 32'd0);
      check($sformatf("conn%0d_settled_k%0d", ch, k), 32'(m_settled), (k >= 12) ? 32'd1 : 32'd0);
    end
    check("conn_ready_high", 32'(m_ready), 32'd1);
    check("conn_busy_low", 32'(m_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    {m_valid, m_en, m_isol, m_ch} = '0;
    {s_valid, s_en, s_isol, s_ch} = '0;
    {t_valid, t_en, t_isol, t_ch} = '0;
    {n_valid, n_en, n_isol, n_ch} = '0;

    #2;
    check("rst_sw", 32'(m_sw), 32'd0);
    check("rst_isol", 32'(m_isol_o), 32'd1);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_settled", 32'(m_settled), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_cur", 32'(m_cur), 32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rel_isol_held", 32'(m_isol_o), 32'd1);
    tick();
    check("open_isol", 32'(m_isol_o), 32'd0);
    check("open_ready", 32'(m_ready), 32'd1);
    check("open_sw", 32'(m_sw), 32'd0);

    // Connect ch2 from OPEN
    main_conn(2'd2);

    // Re-request the connected channel: no-op
    m_valid = 1'b1; m_en = 1'b1; m_ch = 2'd2;
    tick();
    m_valid = 1'b0;
    check("same_err", 32'(m_err), 32'd0);
    check("same_sw", 32'(m_sw), 32'h4);
    check("same_settled", 32'(m_settled), 32'd1);
    check("same_busy", 32'(m_busy), 32'd0);

    // Switch ch2 -> ch1 with dead time
    main_conn(2'd1);

    // Start ch0, isolate during SETTLE
    m_valid = 1'b1; m_en = 1'b1; m_ch = 2'd0;
    tick();
    m_valid = 1'b0;
    repeat (5) tick();
    check("settle_sw", 32'(m_sw), 32'h1);
    check("settle_busy", 32'(m_busy), 32'd1);
    m_isol = 1'b1;
    tick();
    check("isol_sw", 32'(m_sw), 32'd0);
    check("isol_isol", 32'(m_isol_o), 32'd1);
    check("isol_busy", 32'(m_busy), 32'd0);
    check("isol_settled", 32'(m_settled), 32'd0);
    m_isol = 1'b0;
    tick();
    check("isol_rel_isol", 32'(m_isol_o), 32'd0);
    check("isol_rel_ready", 32'(m_ready), 32'd1);
    check("isol_rel_sw", 32'(m_sw), 32'd0);

    // Connect after isolation still waits the dead time
    main_conn(2'd3);

    // Isolation beats a request on the same edge
    m_valid = 1'b1; m_en = 1'b1; m_ch = 2'd1; m_isol = 1'b1;
    tick();
    m_valid = 1'b0; m_isol = 1'b0;
    check("prio_isol", 32'(m_isol_o), 32'd1);
    check("prio_err", 32'(m_err), 32'd0);
    check("prio_sw", 32'(m_sw), 32'd0);
    tick();
    check("prio_open_ready", 32'(m_ready), 32'd1);
    check("prio_cur_kept", 32'(m_cur), 32'd3);

    // Connect ch2 then disconnect
    main_conn(2'd2);
    m_valid = 1'b1; m_en = 1'b0;
    tick();
    m_valid = 1'b0;
    check("disc_sw", 32'(m_sw), 32'd0);
    check("disc_settled", 32'(m_settled), 32'd0);
    check("disc_ready", 32'(m_ready), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("disc_busy_k%0d", k), 32'(m_busy), 32'd1);
    end
    tick();
    check("disc_open_busy", 32'(m_busy), 32'd0);
    check("disc_open_ready", 32'(m_ready), 32'd1);
    check("disc_cur_held", 32'(m_cur), 32'd2);
    check("disc_open_sw", 32'(m_sw), 32'd0);

    // NCH=3: channel 3 is illegal
    t_valid = 1'b1; t_en = 1'b1; t_ch = 2'd3;
    tick();
    t_valid = 1'b0;
    check("ill_err", 32'(t_err), 32'd1);
    check("ill_ready", 32'(t_ready), 32'd1);
    check("ill_busy", 32'(t_busy), 32'd0);
    check("ill_sw", 32'(t_sw), 32'd0);
    tick();
    check("ill_err_pulse", 32'(t_err), 32'd0);
    check("ill_cur", 32'(t_cur), 32'd0);

    // NCH=6: channel 5 connects normally
    s_valid = 1'b1; s_en = 1'b1; s_ch = 3'd5;
    for (int k = 0; k <= 12; k++) begin
      tick();
      s_valid = 1'b0;
      check($sformatf("ch5_sw_k%0d", k), 32'(s_sw), (k >= 4) ? 32'h20 : 32'd0);
      check($sformatf("ch5_settled_k%0d", k), 32'(s_settled), (k >= 12) ? 32'd1 : 32'd0);
    end
    check("ch5_err", 32'(s_err), 32'd0);
    check("ch5_cur", 32'(s_cur), 32'd5);

    // Minimal timing: close one edge after accept, settled one edge later
    n_valid = 1'b1; n_en = 1'b1; n_ch = 2'd1;
    tick();
    n_valid = 1'b0;
    check("min_e0_sw", 32'(n_sw), 32'd0);
    check("min_e0_busy", 32'(n_busy), 32'd1);
    tick();
    check("min_e1_sw", 32'(n_sw), 32'h2);
    check("min_e1_settled", 32'(n_settled), 32'd0);
    tick();
    check("min_e2_settled", 32'(n_settled), 32'd1);
    check("min_e2_busy", 32'(n_busy), 32'd0);

    // Async reset: default instance mid-BREAK, minimal instance mid-SETTLE
    m_valid = 1'b1; m_en = 1'b1; m_ch = 2'd1;
    n_valid = 1'b1; n_en = 1'b1; n_ch = 2'd3;
    tick();
    m_valid = 1'b0; n_valid = 1'b0;
    tick();
    check("pre_rst_m_busy", 32'(m_busy), 32'd1);
    check("pre_rst_m_cur", 32'(m_cur), 32'd1);
    check("pre_rst_n_sw", 32'(n_sw), 32'h8);
    #2 rst = 1'b1;
    #1;
    check("arst_m_sw", 32'(m_sw), 32'd0);
    check("arst_m_isol", 32'(m_isol_o), 32'd1);
    check("arst_m_busy", 32'(m_busy), 32'd0);
    check("arst_m_cur", 32'(m_cur), 32'd0);
    check("arst_m_ready", 32'(m_ready), 32'd0);
    check("arst_n_sw", 32'(n_sw), 32'd0);
    check("arst_n_isol", 32'(n_isol_o), 32'd1);
    check("arst_n_busy", 32'(n_busy), 32'd0);
    check("arst_n_cur", 32'(n_cur), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_analog_sw_ctrl.md
Name: pad_analog_sw_ctrl

Overview:
- Parametrised controller for a bank of NCH generic analog pads.
- Each pad is joined to a shared internal analog node through a pad-side switch cell driven by SW_EN[i].
- Enforces at most one closed switch at a time, break-before-make with a programmable dead time, and a settle interval before reporting the connection usable.
- Holds a global isolation state (all switches open) across reset and on demand. Sits between the AHB/APB register block that issues requests and the pad ring.

Parameters:
- NCH, 4, number of analog pads/switches (2..32)
- DEAD_CYCLES, 4, cycles all switches held open between any open and the next close (>=1)
- SETTLE_CYCLES, 8, cycles after a close before SETTLED asserts (>=1)
- CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
- CLK, input, 1, single clock
- RESET, input, 1, asynchronous active-high reset
- SEL_VALID, input, 1, request valid
- SEL_READY, output, 1, controller can accept a request
- SEL_EN, input, 1, 1 = connect SEL_CH, 0 = disconnect all
- SEL_CH, input, CHW, channel to connect
- ISOL_REQ, input, 1, force isolation (level)
- SW_EN, output, NCH, switch enables to pad cells; one-hot or zero
- CUR_CH, output, CHW, index of connected/connecting channel
- ISOL, output, 1, bank isolated
- BUSY, output, 1, BREAK or SETTLE in progress
- SETTLED, output, 1, CUR_CH connected and settled
- ERR, output, 1, one-cycle pulse on rejected request

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset RESET is asynchronous, active-high.
  - All outputs are registered.
- Reset values: state ISOLATED, SW_EN=0, CUR_CH=0, ISOL=1, BUSY=0, SETTLED=0, ERR=0, SEL_READY=0.
- States: ISOLATED, OPEN, BREAK, SETTLE, CONNECTED.
  - ISOLATED: SW_EN=0, ISOL=1. Moves to OPEN on the first edge with ISOL_REQ=0.
  - OPEN: SW_EN=0, SEL_READY=1.
  - CONNECTED: SW_EN=onehot(CUR_CH), SETTLED=1, SEL_READY=1.
  - BREAK and SETTLE: BUSY=1, SEL_READY=0.
- Accept: a request is taken on an edge where SEL_VALID && SEL_READY. Call that edge E0.
- Connect request, legal channel (SEL_EN=1, SEL_CH<NCH, not already connected to SEL_CH):
  - After E0: BREAK, SW_EN=0, CUR_CH=SEL_CH, SETTLED=0.
  - After E0+DEAD_CYCLES: SETTLE, SW_EN=onehot(CUR_CH).
  - After E0+DEAD_CYCLES+SETTLE_CYCLES: CONNECTED.
  - The dead time is applied even when the request comes from OPEN.
- Connect to the channel already in CONNECTED: no-op. State, SW_EN and SETTLED are unchanged; no ERR.
- Disconnect (SEL_EN=0):
  - After E0: BREAK, SW_EN=0, SETTLED=0.
  - After E0+DEAD_CYCLES: OPEN. CUR_CH holds its last value.
- Illegal channel (SEL_EN=1, SEL_CH>=NCH): ERR=1 for exactly the cycle after E0. State and SW_EN are unchanged.
- Requests are not queued. SEL_VALID while SEL_READY=0 is simply not accepted.
- Isolation:
  - ISOL_REQ=1 on any edge, in any state, gives ISOLATED on that edge: SW_EN=0, ISOL=1, BUSY=0, SETTLED=0, and any count in progress is aborted.
  - Isolation takes priority over a request accepted on the same edge; that request is dropped with no ERR.
  - When ISOL_REQ falls, the block goes to OPEN one edge later. The next close still waits DEAD_CYCLES, because every close passes through BREAK.
- RESET mid-BREAK or mid-SETTLE: SW_EN clears asynchronously. The pending request is lost.
- Invariants that must hold on every cycle:
  - popcount(SW_EN) <= 1.
  - Between SW_EN falling from any bit and any bit rising there are at least DEAD_CYCLES cycles of SW_EN=0.
  - SETTLED implies SW_EN != 0.
- Counters:
  - One down-counter, width $clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1).
  - Loaded on entry to BREAK and to SETTLE; the transition fires when the count reaches 0.
  - No wrap-around is possible.

Decomposition:
- Package pad_analog_pkg holds:
  - the state enum pad_analog_state_t
  - the onehot function for CHW->NCH
  - the constant-width helper for counter sizing
- Sub-module pad_analog_timer: loadable down-counter with load, value and zero flag, reused by future pad sequencers.
- FSM and output registers stay in pad_analog_sw_ctrl.

Test Plan:
- Reset release with ISOL_REQ=0 (defaults NCH=4, DEAD=4, SETTLE=8) -> ISOL=1 in the reset cycle, OPEN one edge later, SEL_READY=1, SW_EN=4'b0000.
- Connect ch2 from OPEN at E0 -> SW_EN=0 for cycles E0+1..E0+4, SW_EN=4'b0100 from E0+4, SETTLED=1 and SEL_READY=1 at E0+12.
- Connected to ch2, request ch1 -> SW_EN 4'b0100 -> 4'b0000 for exactly 4 cycles -> 4'b0010. Popcount never exceeds 1; SETTLED low for 12 cycles.
- Request SEL_CH=5 with NCH=6 overridden, plus SEL_CH=3 with NCH=3 -> ch5 connects normally; SEL_CH=3 gives ERR one-cycle pulse with no state change. Re-request of the current channel -> no ERR, SW_EN stable.
- ISOL_REQ pulsed 1 during SETTLE (SW_EN=4'b0001) -> SW_EN=0 and ISOL=1 on that edge, BUSY=0. After release, OPEN; a subsequent connect still shows 4 dead cycles.
- RESET asserted asynchronously mid-BREAK, and again with DEAD=1/SETTLE=1 -> outputs reach their reset values without a clock edge. The minimal-parameter run gives close one cycle after accept and SETTLED one cycle later.
